// File: rtl/ascii_seg7_scroller.sv
// ASCII-to-7-segment display stage: small character FIFO feeding a show/gap display sequencer.
// Optional macro SEG7_DP_HEARTBEAT_EN lights the decimal point on alternate glyphs.
//
// state | meaning
// IDLE  | nothing displayed, waiting for a buffered character
// SHOW  | glyph on seg, timer counting down the hold time
// GAP   | seg blanked, timer counting down the gap time
module ascii_seg7_scroller #(
   parameter int DEPTH       = 4,
   parameter int HOLD_CYCLES = 1000,
   parameter int GAP_CYCLES  = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic [7:0] seg,
   output logic       busy
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;
   localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(MAXC + 1);
   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD  = (GAP_CYCLES > 0) ? TW'(GAP_CYCLES - 1) : '0;
   localparam bit NO_GAP = (GAP_CYCLES == 0);

   typedef enum logic [1:0] {ST_IDLE, ST_SHOW, ST_GAP} state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CNTW-1:0] count;
   logic            empty, full, push, load, tc;
   logic [6:0]      head_glyph;
`ifdef SEG7_DP_HEARTBEAT_EN
   logic            dp_flag;
`endif

   function automatic logic [6:0] glyph(input logic [7:0] ch);
      logic [7:0] u;
      u = (ch >= 8'h61 && ch <= 8'h7A) ? ch - 8'd32 : ch;
      case (u)
         "0": glyph = 7'h3F;  "1": glyph = 7'h06;  "2": glyph = 7'h5B;  "3": glyph = 7'h4F;
         "4": glyph = 7'h66;  "5": glyph = 7'h6D;  "6": glyph = 7'h7D;  "7": glyph = 7'h07;
         "8": glyph = 7'h7F;  "9": glyph = 7'h6F;
         "A": glyph = 7'h77;  "B": glyph = 7'h7C;  "C": glyph = 7'h39;  "D": glyph = 7'h5E;
         "E": glyph = 7'h79;  "F": glyph = 7'h71;  "G": glyph = 7'h3D;  "H": glyph = 7'h76;
         "I": glyph = 7'h30;  "J": glyph = 7'h1E;  "K": glyph = 7'h75;  "L": glyph = 7'h38;
         "M": glyph = 7'h37;  "N": glyph = 7'h54;  "O": glyph = 7'h5C;  "P": glyph = 7'h73;
         "Q": glyph = 7'h67;  "R": glyph = 7'h50;  "S": glyph = 7'h6D;  "T": glyph = 7'h78;
         "U": glyph = 7'h3E;  "V": glyph = 7'h1C;  "W": glyph = 7'h2A;  "X": glyph = 7'h76;
         "Y": glyph = 7'h6E;  "Z": glyph = 7'h5B;
         " ": glyph = 7'h00;
         default: glyph = 7'h40;
      endcase
   endfunction

   // load = pop the FIFO head onto the display; gap-less builds chain glyphs straight from SHOW
   always_comb begin
      empty      = (count == '0);
      full       = (count == CNTW'(DEPTH));
      char_ready = ena & ~full;
      push       = char_valid & char_ready;
      tc         = (timer == '0);
      load       = ena & ~empty & ((state == ST_IDLE) |
                                   (state == ST_SHOW & tc & NO_GAP) |
                                   (state == ST_GAP & tc));
      busy       = (state != ST_IDLE) | ~empty;
      head_glyph = glyph(mem[rd_ptr]);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= char_in;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (load) rd_ptr <= rd_ptr + AW'(1);
         if (push & ~load)      count <= count + CNTW'(1);
         else if (~push & load) count <= count - CNTW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         timer <= '0;
         seg   <= 8'h00;
`ifdef SEG7_DP_HEARTBEAT_EN
         dp_flag <= 1'b0;
`endif
      end else if (ena) begin
         if (load) begin
            state <= ST_SHOW;
            timer <= HOLD_LD;
`ifdef SEG7_DP_HEARTBEAT_EN
            dp_flag <= ~dp_flag;
            seg     <= {~dp_flag, head_glyph};
`else
            seg     <= {1'b0, head_glyph};
`endif
         end else begin
            case (state)
               ST_IDLE: seg <= 8'h00;
               ST_SHOW: begin
                  if (!tc) begin
                     timer <= timer - TW'(1);
                  end else if (!NO_GAP) begin
                     seg   <= 8'h00;
                     timer <= GAP_LD;
                     state <= ST_GAP;
                  end else begin
                     seg   <= 8'h00;
                     state <= ST_IDLE;
                  end
               end
               ST_GAP: begin
                  if (!tc) begin
                     timer <= timer - TW'(1);
                  end else begin
                     seg   <= 8'h00;
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  seg   <= 8'h00;
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ascii_seg7_scroller.sv
// Self-checking bench for ascii_seg7_scroller: directed scenarios plus random traffic against
// a slot-based reference model (each accepted char occupies HOLD+GAP display cycles).
module tb_ascii_seg7_scroller;
   localparam int DEPTH = 4;
   localparam int HOLD  = 3;
   localparam int GAP   = 1;

   localparam logic [7:0] DIG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                       8'h7F, 8'h6F};
   localparam logic [7:0] LET [26] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76,
                                       8'h30, 8'h1E, 8'h75, 8'h38, 8'h37, 8'h54, 8'h5C, 8'h73,
                                       8'h67, 8'h50, 8'h6D, 8'h78, 8'h3E, 8'h1C, 8'h2A, 8'h76,
                                       8'h6E, 8'h5B};

   logic       clk, rst_n, ena, char_valid;
   logic [7:0] char_in;
   logic       char_ready, busy;
   logic [7:0] seg;

   ascii_seg7_scroller #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .char_in(char_in), .char_valid(char_valid),
      .char_ready(char_ready), .seg(seg), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   byte unsigned q[$];
   int           slot_left;
   logic [6:0]   cur;
   bit           dp;
   bit           last_acc;
   int           total, passed, fails;

   function automatic logic [6:0] tb_glyph(byte unsigned c);
      byte unsigned u;
      logic [7:0]   t;
      u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'd32 : c;
      if (u >= 8'h30 && u <= 8'h39)      t = DIG[u - 8'h30];
      else if (u >= 8'h41 && u <= 8'h5A) t = LET[u - 8'h41];
      else if (u == 8'h20)               t = 8'h00;
      else                               t = 8'h40;
      return t[6:0];
   endfunction

   function automatic logic [7:0] exp_seg();
      logic dp_bit;
`ifdef SEG7_DP_HEARTBEAT_EN
      dp_bit = dp;
`else
      dp_bit = 1'b0;
`endif
      return (slot_left > GAP) ? {dp_bit, cur} : 8'h00;
   endfunction

   task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(bit v, byte unsigned c, bit e, bit r);
      bit acc;
      char_valid = v;
      char_in    = c;
      ena        = e;
      rst_n      = r;
      #1;
      check("char_ready", {7'b0, char_ready}, {7'b0, (e && q.size() < DEPTH)});
      acc = v && e && (q.size() < DEPTH);
      @(posedge clk);
      if (!r) begin
         q.delete();
         slot_left = 0;
         dp = 1'b0;
         acc = 1'b0;
      end else if (e) begin
         if (slot_left > 0) slot_left--;
         if (slot_left == 0 && q.size() > 0) begin
            cur = tb_glyph(q.pop_front());
            dp = ~dp;
            slot_left = HOLD + GAP;
         end
         if (acc) q.push_back(c);
      end
      last_acc = acc;
      #1;
      check("seg", seg, exp_seg());
      check("busy", {7'b0, busy}, {7'b0, (slot_left > 0 || q.size() > 0)});
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b1, 1'b1);
   endtask

   task automatic send_held(byte unsigned c);
      int n;
      n = 0;
      do begin
         tick(1'b1, c, 1'b1, 1'b1);
         n++;
      end while (!last_acc && n < 50);
   endtask

   initial begin
      string six;
      total = 0; passed = 0; fails = 0;
      slot_left = 0; cur = '0; dp = 1'b0; last_acc = 1'b0;
      rst_n = 1'b0; ena = 1'b1; char_valid = 1'b0; char_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      check("reset_seg", seg, 8'h00);
      check("reset_busy", {7'b0, busy}, 8'h00);

      tick(1'b1, "T", 1'b1, 1'b1);
      idle(6);

      tick(1'b1, "S", 1'b1, 1'b1);
      tick(1'b1, "a", 1'b1, 1'b1);
      idle(10);

      six = "Hello7";
      for (int i = 0; i < 6; i++) send_held(six[i]);
      idle(30);

      tick(1'b1, " ", 1'b1, 1'b1);
      tick(1'b1, "#", 1'b1, 1'b1);
      idle(10);

      tick(1'b1, "K", 1'b1, 1'b1);
      idle(1);
      for (int i = 0; i < 5; i++) tick(1'b1, "Z", 1'b0, 1'b1);
      idle(8);

      tick(1'b1, "A", 1'b1, 1'b1);
      tick(1'b1, "B", 1'b1, 1'b1);
      tick(1'b1, "C", 1'b1, 1'b1);
      tick(1'b0, 8'h00, 1'b1, 1'b0);
      idle(2);
      tick(1'b1, "D", 1'b1, 1'b1);
      idle(8);

      for (int i = 0; i < 500; i++)
         tick(1'($urandom_range(0, 1)), 8'($urandom_range(32, 126)),
              ($urandom_range(0, 7) != 0), ($urandom_range(0, 99) != 0));
      idle(40);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
